// File: rtl/br_delay_serializer_if.sv
// br_delay_serializer_if: parallel push / serial pop handshake bundle.
interface br_delay_serializer_if #(
  parameter int Width     = 1,
  parameter int NumStages = 2
);
  logic                             push_valid;
  logic                             push_ready;
  logic [NumStages-1:0][Width-1:0]  push_data;
  logic                             pop_valid;
  logic                             pop_ready;
  logic [Width-1:0]                 pop_data;
  logic                             pop_last;
  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_last
  );
  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, pop_last
  );
endinterface

// File: rtl/br_delay_serializer.sv
// br_delay_serializer: emits a NumStages x Width word as beats, highest index first.
// Optional abort input when BR_DELAY_SERIALIZER_ABORT_EN is defined.
module br_delay_serializer #(
  parameter int Width     = 1,
  parameter int NumStages = 2
) (
  input logic clk,
  input logic rst,
`ifdef BR_DELAY_SERIALIZER_ABORT_EN
  input logic abort,
`endif
  br_delay_serializer_if.slave ser
);
  localparam int CW = NumStages > 1 ? $clog2(NumStages) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NumStages-1:0][Width-1:0] word_q, word_d;
  logic busy, last, abort_s, pop_fire, push_fire;
  if (Width < 1 || NumStages < 1) begin : g_bad_params
    $error("br_delay_serializer: Width and NumStages must be >= 1");
  end
`ifdef BR_DELAY_SERIALIZER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif
  assign busy           = state_q == BUSY;
  assign last           = busy && cnt_q == '0;
  assign ser.pop_valid  = busy;
  assign ser.pop_data   = word_q[cnt_q];
  assign ser.pop_last   = last;
  // Ready follows pop_ready on the last beat so words stream with no bubble.
  assign ser.push_ready = !abort_s && (!busy || (last && ser.pop_ready));
  assign push_fire      = ser.push_valid && ser.push_ready;
  assign pop_fire       = busy && ser.pop_ready && !abort_s;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (push_fire) begin
      state_d = BUSY;
      cnt_d   = CW'(NumStages - 1);
      word_d  = ser.push_data;
    end else if (busy && abort_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (pop_fire) begin
      state_d = last ? IDLE : BUSY;
      cnt_d   = last ? cnt_q : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    busy && !ser.pop_ready && !abort_s |=> $stable(ser.pop_data) && ser.pop_valid);
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CW'(NumStages - 1));
endmodule
